// File: rtl/pulse_filter_meter.sv
// Glitch filter and pulse-width meter for one asynchronous input: synchronizes,
// debounces over STABLE_CYCLES samples, counts rejected highs and reports high widths.
module pulse_filter_meter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  output logic             filt_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [7:0]       glitch_cnt,
  output logic             width_valid,
  input  logic             width_ready,
  output logic [CNT_W-1:0] width_data,
  output logic             width_ovf,
  output logic             width_drop
);

  localparam int SC_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {LOW, ARM_HIGH, HIGH, ARM_LOW} state_t;

  state_t                 state, state_nxt;
  logic [SC_W-1:0]        sc, sc_nxt;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic                   glitch_hit;
  logic                   filt_d, rise_d, fall_d;
  logic [CNT_W-1:0]       wcnt;
  logic                   ovf_pend;

  function automatic logic [7:0] glitch_sat_inc(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  function automatic logic [CNT_W-1:0] width_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Synchronizer stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_p0 <= '0;
    else        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], a_in};
  end

  assign s = sync_p0[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOW;
      sc    <= '0;
    end else begin
      state <= state_nxt;
      sc    <= sc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sc_nxt     = sc;
    glitch_hit = 1'b0;
    case (state)
      LOW: begin
        if (s) begin
          state_nxt = (STABLE_CYCLES == 1) ? HIGH : ARM_HIGH;
          sc_nxt    = SC_W'(1);
        end
      end
      ARM_HIGH: begin
        if (s) begin
          sc_nxt = sc + SC_W'(1);
          if (sc == SC_LAST - SC_W'(1)) state_nxt = HIGH;
        end else begin
          state_nxt  = LOW;
          glitch_hit = 1'b1;
        end
      end
      HIGH: begin
        if (!s) begin
          state_nxt = (STABLE_CYCLES == 1) ? LOW : ARM_LOW;
          sc_nxt    = SC_W'(1);
        end
      end
      ARM_LOW: begin
        if (!s) begin
          sc_nxt = sc + SC_W'(1);
          if (sc == SC_LAST - SC_W'(1)) state_nxt = LOW;
        end else begin
          // Low dropouts are absorbed without being counted
          state_nxt = HIGH;
        end
      end
      default: state_nxt = LOW;
    endcase
  end

  always_comb begin
    filt_d = (state_nxt == HIGH) || (state_nxt == ARM_LOW);
    rise_d = filt_d & ~filt_out;
    fall_d = ~filt_d & filt_out;
  end

  // Filtered level / strobe stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_out   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      filt_out   <= filt_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      if (glitch_hit) glitch_cnt <= glitch_sat_inc(glitch_cnt);
    end
  end

  // Width counter stage: wcnt equals the number of cycles filt_out has been high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt     <= '0;
      ovf_pend <= 1'b0;
    end else if (rise_d) begin
      wcnt     <= CNT_W'(1);
      ovf_pend <= 1'b0;
    end else if (filt_d && filt_out) begin
      if (&wcnt) ovf_pend <= 1'b1;
      wcnt <= width_sat_inc(wcnt);
    end
  end

  // Measurement handshake stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_valid <= 1'b0;
      width_data  <= '0;
      width_ovf   <= 1'b0;
      width_drop  <= 1'b0;
    end else if (fall_d) begin
      if (!width_valid || width_ready) begin
        width_valid <= 1'b1;
        width_data  <= wcnt;
        width_ovf   <= ovf_pend;
      end else begin
        width_drop  <= 1'b1;
      end
    end else if (width_valid && width_ready) begin
      width_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_filter_meter.sv
// Directed bench for pulse_filter_meter at default parameters; inputs change and
// outputs are sampled 1 ns after each rising clock edge.
module tb_pulse_filter_meter;

  logic       clk;
  logic       rst_n;
  logic       a_in;
  logic       filt_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] glitch_cnt;
  logic       width_valid;
  logic       width_ready;
  logic [7:0] width_data;
  logic       width_ovf;
  logic       width_drop;

  int passed = 0;
  int total  = 0;

  logic filt_seen  = 1'b0;
  logic rise_seen  = 1'b0;
  logic valid_seen = 1'b0;
  int   fall_n     = 0;

  pulse_filter_meter #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(3),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_in       (a_in),
    .filt_out   (filt_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .glitch_cnt (glitch_cnt),
    .width_valid(width_valid),
    .width_ready(width_ready),
    .width_data (width_data),
    .width_ovf  (width_ovf),
    .width_drop (width_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (filt_out === 1'b1)    filt_seen  = 1'b1;
    if (rise_pulse === 1'b1)  rise_seen  = 1'b1;
    if (width_valid === 1'b1) valid_seen = 1'b1;
    if (fall_pulse === 1'b1)  fall_n     = fall_n + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic pulse(input int n);
    a_in = 1'b1;
    cyc(n);
    a_in = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    a_in        = 1'b1;
    width_ready = 1'b1;
    cyc(4);
    chk("rst_filt",   32'(filt_out),    0);
    chk("rst_rise",   32'(rise_pulse),  0);
    chk("rst_fall",   32'(fall_pulse),  0);
    chk("rst_glitch", 32'(glitch_cnt),  0);
    chk("rst_valid",  32'(width_valid), 0);
    chk("rst_drop",   32'(width_drop),  0);

    // Release with a_in already high: filt_out rises 5 cycles later
    rst_n = 1'b1;
    cyc(4);
    chk("rel_filt_early", 32'(filt_out), 0);
    cyc(1);
    chk("rel_filt",  32'(filt_out),   1);
    chk("rel_rise",  32'(rise_pulse), 1);
    a_in = 1'b0;
    cyc(5);
    chk("rel_fall",  32'(fall_pulse),  1);
    chk("rel_valid", 32'(width_valid), 1);
    chk("rel_width", 32'(width_data),  5);
    cyc(1);
    chk("rel_valid_clr", 32'(width_valid), 0);

    // 10-cycle clean pulse
    a_in = 1'b1;
    cyc(4);
    chk("p10_rise_early", 32'(rise_pulse), 0);
    cyc(1);
    chk("p10_rise", 32'(rise_pulse), 1);
    chk("p10_filt", 32'(filt_out),   1);
    cyc(1);
    chk("p10_rise_once", 32'(rise_pulse), 0);
    cyc(4);
    a_in = 1'b0;
    cyc(4);
    chk("p10_fall_early", 32'(fall_pulse), 0);
    cyc(1);
    chk("p10_fall",  32'(fall_pulse),  1);
    chk("p10_valid", 32'(width_valid), 1);
    chk("p10_width", 32'(width_data),  10);
    chk("p10_ovf",   32'(width_ovf),   0);
    cyc(1);
    chk("p10_valid_clr", 32'(width_valid), 0);
    chk("p10_fall_once", 32'(fall_pulse),  0);

    // Glitches: 1-cycle, 2-cycle and a sub-cycle pulse away from the clock edge
    filt_seen  = 1'b0;
    rise_seen  = 1'b0;
    valid_seen = 1'b0;
    pulse(1);
    cyc(6);
    pulse(2);
    cyc(6);
    a_in = 1'b1;
    #1;
    a_in = 1'b0;
    cyc(6);
    chk("gl_count",      32'(glitch_cnt), 2);
    chk("gl_filt_seen",  32'(filt_seen),  0);
    chk("gl_rise_seen",  32'(rise_seen),  0);
    chk("gl_valid_seen", 32'(valid_seen), 0);

    // 20-cycle high with a 2-cycle low dropout
    fall_n = 0;
    pulse(9);
    cyc(2);
    pulse(9);
    cyc(4);
    chk("dr_filt_held", 32'(filt_out), 1);
    cyc(1);
    chk("dr_fall",   32'(fall_pulse), 1);
    chk("dr_width",  32'(width_data), 20);
    chk("dr_glitch", 32'(glitch_cnt), 2);
    cyc(1);
    chk("dr_fall_n", fall_n, 1);

    // Overflow: 300-cycle pulse, then a short one clears width_ovf
    pulse(300);
    cyc(5);
    chk("ov_valid", 32'(width_valid), 1);
    chk("ov_width", 32'(width_data),  255);
    chk("ov_ovf",   32'(width_ovf),   1);
    cyc(10);
    pulse(4);
    cyc(5);
    chk("ov4_width", 32'(width_data), 4);
    chk("ov4_ovf",   32'(width_ovf),  0);
    cyc(1);
    chk("ov4_valid_clr", 32'(width_valid), 0);

    // New measurement lands in the same cycle as a transfer
    width_ready = 1'b0;
    pulse(3);
    cyc(5);
    chk("co_valid1", 32'(width_valid), 1);
    chk("co_width1", 32'(width_data),  3);
    cyc(3);
    pulse(6);
    cyc(4);
    chk("co_hold", 32'(width_data), 3);
    width_ready = 1'b1;
    cyc(1);
    chk("co_valid2", 32'(width_valid), 1);
    chk("co_width2", 32'(width_data),  6);
    chk("co_drop",   32'(width_drop),  0);
    cyc(1);
    chk("co_valid_clr", 32'(width_valid), 0);

    // Back-pressure: second measurement dropped
    width_ready = 1'b0;
    pulse(8);
    cyc(5);
    chk("bp_valid1", 32'(width_valid), 1);
    chk("bp_width1", 32'(width_data),  8);
    chk("bp_drop1",  32'(width_drop),  0);
    cyc(5);
    pulse(8);
    cyc(5);
    chk("bp_valid2", 32'(width_valid), 1);
    chk("bp_width2", 32'(width_data),  8);
    chk("bp_drop2",  32'(width_drop),  1);
    width_ready = 1'b1;
    cyc(1);
    chk("bp_xfer",      32'(width_valid), 0);
    chk("bp_drop_held", 32'(width_drop),  1);
    cyc(1);
    chk("bp_idle", 32'(width_valid), 0);
    width_ready = 1'b0;

    // Glitch counter saturation
    for (int i = 0; i < 260; i++) begin
      pulse(1);
      cyc(3);
    end
    cyc(3);
    chk("gl_sat", 32'(glitch_cnt), 255);

    // Asynchronous reset in the middle of a pulse
    pulse(8);
    a_in = 1'b1;
    chk("ar_filt_before", 32'(filt_out), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_filt",   32'(filt_out),    0);
    chk("ar_rise",   32'(rise_pulse),  0);
    chk("ar_fall",   32'(fall_pulse),  0);
    chk("ar_glitch", 32'(glitch_cnt),  0);
    chk("ar_valid",  32'(width_valid), 0);
    chk("ar_data",   32'(width_data),  0);
    chk("ar_ovf",    32'(width_ovf),   0);
    chk("ar_drop",   32'(width_drop),  0);
    a_in = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pulse_filter_meter.md
Name: pulse_filter_meter

Overview:
- Downstream consumer of the delay-modelling stage: takes one asynchronous single-bit waveform that may contain sub-cycle glitches, such as the delayed outputs under study.
- Synchronizes it into the clk domain and rejects pulses shorter than STABLE_CYCLES.
- Emits a clean filtered level with rise/fall strobes, counts rejected glitches, and reports each accepted high pulse width through a valid/ready handshake.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops (min 2)
STABLE_CYCLES, 3, consecutive synchronized samples required before the filtered level changes (min 1)
CNT_W, 8, width of the pulse-width counter and width_data

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
a_in  input  1  asynchronous input waveform
filt_out  output  1  filtered, synchronized level
rise_pulse  output  1  one-cycle strobe on filt_out 0->1
fall_pulse  output  1  one-cycle strobe on filt_out 1->0
glitch_cnt  output  8  saturating count of rejected pulses
width_valid  output  1  width_data holds an unconsumed measurement
width_ready  input  1  consumer accepts width_data when high with width_valid
width_data  output  CNT_W  high time of last accepted pulse, in clk cycles
width_ovf  output  1  width_data saturated (pulse longer than 2^CNT_W-1)
width_drop  output  1  sticky: a measurement was lost because the previous one was unconsumed

Behaviour:
- Reset (rst_n low, asynchronous): all synchronizer flops, filt_out, strobes, glitch_cnt, width_valid, width_data, width_ovf, width_drop and internal counters go to 0; FSM enters LOW. Reset is honoured mid-pulse or mid-handshake with no partial result retained.
- Synchronizer: a_in passes through SYNC_STAGES flops; s = last stage.
- FSM states: LOW, ARM_HIGH, HIGH, ARM_LOW. Stability counter sc counts ARM samples.
  - LOW: s=1 -> ARM_HIGH, sc=1. If STABLE_CYCLES=1, go straight to HIGH.
  - ARM_HIGH: s=1 -> sc++. When sc reaches STABLE_CYCLES -> HIGH. s=0 -> LOW, glitch_cnt++.
  - HIGH: s=0 -> ARM_LOW, sc=1.
  - ARM_LOW: s=0 -> sc++. When sc reaches STABLE_CYCLES -> LOW. s=1 -> HIGH, no glitch count.
  - Only high glitches are counted. Low dropouts are absorbed silently.
- filt_out is 1 in HIGH and ARM_LOW; registered.
- Latency: a clock-aligned a_in edge, held stable, appears on filt_out SYNC_STAGES+STABLE_CYCLES cycles later (5 at defaults).
- rise_pulse / fall_pulse: high for exactly the first cycle in which filt_out shows the new value.
- glitch_cnt saturates at 255 and never wraps.
- Width counter:
  - Loads 1 on the cycle filt_out becomes 1.
  - Increments each further cycle filt_out=1, saturating at 2^CNT_W-1; saturation sets a pending ovf bit.
  - On fall_pulse, width_data receives the count of cycles filt_out was 1, and width_ovf receives the pending bit.
- Handshake:
  - width_valid rises in the fall_pulse cycle.
  - Transfer occurs when width_valid && width_ready at a clk edge; width_valid then clears unless a new measurement loads in the same cycle.
  - width_data and width_ovf are stable while width_valid=1 and not accepted.
  - New measurement while width_valid=1 and width_ready=0: new value discarded, old held, width_drop set and held until reset.
  - New measurement in the same cycle as a transfer: new value loads, width_valid stays 1, no drop.
- width_ready while width_valid=0: ignored.

Test Plan (defaults unless stated):
- Hold rst_n=0 with a_in=1 for 4 cycles -> filt_out, strobes, glitch_cnt, width_valid, width_drop all 0. Release -> filt_out rises 5 cycles later.
- a_in high for 10 clock-aligned cycles, width_ready=1 -> rise_pulse 5 cycles after the edge. fall_pulse 10 cycles after rise_pulse. width_valid for 1 cycle with width_data=10, width_ovf=0.
- a_in pulses of 1 and 2 cycles, plus a 1 ns sub-cycle pulse, separated by 6 low cycles -> filt_out stays 0; glitch_cnt=2 (or 3 if the sub-cycle pulse is sampled); no width_valid.
- Clean high for 20 cycles containing a 2-cycle low dropout -> filt_out stays 1 throughout, one fall_pulse only, width_data=20, glitch_cnt unchanged.
- CNT_W=8, a_in high for 300 cycles -> width_data=255, width_ovf=1. A following 4-cycle pulse -> width_data=4, width_ovf=0.
- width_ready=0, two 8-cycle pulses -> width_data=8 held, width_drop=1. Raise width_ready -> one transfer, then width_valid=0. Assert rst_n=0 mid-pulse -> all outputs 0 immediately, before the next clk edge.
